calc_opcode_builder: RTL and testbench

//   Keypad-side front end for the calculator datapath. Collects digit and operator
//   key presses and packs them into the 14-bit calculator opcode word. Drives that

---
 rtl/calc_pkg.sv | 29 ++
 rtl/calc_settle_timer.sv | 35 +++
 rtl/calc_opcode_builder.sv | 165 ++++++++++++++++
 tb/tb_calc_opcode_builder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the keypad-to-calculator opcode builder.
// Opcode layout is {sel[1:0], a[3:0], b[3:0], 4'b0000}.
package calc_pkg;

  localparam int OPCODE_W = 14;
  localparam int SEL_MSB  = 13;
  localparam int A_MSB    = 11;
  localparam int B_MSB    = 7;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_NEG = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_A     = 3'd1,
    S_OP    = 3'd2,
    S_ISSUE = 3'd3,
    S_RES   = 3'd4
  } state_e;

  function automatic logic [OPCODE_W-1:0] pack_opcode(input logic [1:0] sel,
                                                      input logic [3:0] a,
                                                      input logic [3:0] b);
    return {sel, a, b, 4'b0000};
  endfunction

endpackage

// File: rtl/calc_settle_timer.sv
// Loadable down-counter that measures the ISSUE settle window.
// done is high during the last enabled cycle of the window.
module calc_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  logic [CW-1:0] count;

  // Count down from SETTLE_CYCLES once loaded on ISSUE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(SETTLE_CYCLES);
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end else begin
      count <= count;
    end
  end

  assign done = en && (count == CW'(1));

endmodule

// File: rtl/calc_opcode_builder.sv
// Collects key presses into a calculator opcode, presents it and captures z.
// Optional feature macro: CALC_RESULT_CHAIN_EN (ISSUE exits to RES for chaining).
module calc_opcode_builder
  import calc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  input  logic                key_is_op,
  input  logic [3:0]          key_val,
  input  logic                key_clr,
  output logic                key_ready,
  output logic [OPCODE_W-1:0] opcode,
  output logic                opcode_valid,
  input  logic [3:0]          z,
  output logic [3:0]          res,
  output logic                res_valid,
  output logic                err
);

  state_e     state, next_state;
  logic [3:0] a, b, a_n, b_n;
  logic [1:0] sel, sel_n, op;
  logic       err_n, accept, done, enter_issue, capture, pend;
  logic [3:0] z_hold;

  assign accept      = key_valid & key_ready;
  assign op          = key_val[1:0];
  assign enter_issue = (next_state == S_ISSUE) && (state != S_ISSUE);
  assign capture     = (state == S_ISSUE) && done && !key_clr;

`ifdef CALC_RESULT_CHAIN_EN
  logic [3:0] res_src;
  // A result still in flight to res is the freshest value to chain from.
  assign res_src = pend ? z_hold : res;
`endif

  calc_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (key_clr),
    .load  (enter_issue),
    .en    (state == S_ISSUE),
    .done  (done)
  );

  // Next-state, operand fields and error decode.
  always_comb begin
    next_state = state;
    a_n        = a;
    b_n        = b;
    sel_n      = sel;
    err_n      = 1'b0;
    if (key_clr) begin
      next_state = S_IDLE;
      a_n        = 4'h0;
      b_n        = 4'h0;
      sel_n      = OP_ADD;
    end else if (state == S_ISSUE) begin
`ifdef CALC_RESULT_CHAIN_EN
      next_state = done ? S_RES : S_ISSUE;
`else
      next_state = done ? S_IDLE : S_ISSUE;
`endif
    end else if (accept) begin
      case (state)
        S_IDLE: begin
          if (key_is_op) begin
            err_n = 1'b1;
          end else begin
            a_n        = key_val;
            next_state = S_A;
          end
        end
        S_A: begin
          if (!key_is_op) begin
            a_n = key_val;
          end else begin
            sel_n = op;
            if (op == OP_NEG) begin
              b_n        = 4'h0;
              next_state = S_ISSUE;
            end else begin
              next_state = S_OP;
            end
          end
        end
        S_OP: begin
          if (!key_is_op) begin
            b_n        = key_val;
            next_state = S_ISSUE;
          end else begin
            sel_n = op;
            if (op == OP_NEG) begin
              b_n        = 4'h0;
              next_state = S_ISSUE;
            end else begin
              next_state = S_OP;
            end
          end
        end
`ifdef CALC_RESULT_CHAIN_EN
        S_RES: begin
          if (!key_is_op) begin
            a_n        = key_val;
            next_state = S_A;
          end else begin
            a_n   = res_src;
            sel_n = op;
            if (op == OP_NEG) begin
              b_n        = 4'h0;
              next_state = S_ISSUE;
            end else begin
              next_state = S_OP;
            end
          end
        end
`endif
        default: begin
          next_state = S_IDLE;
        end
      endcase
    end else begin
      next_state = state;
    end
  end

  // State, fields, opcode and the two-stage result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      a            <= 4'h0;
      b            <= 4'h0;
      sel          <= OP_ADD;
      err          <= 1'b0;
      key_ready    <= 1'b0;
      opcode_valid <= 1'b0;
      opcode       <= '0;
      pend         <= 1'b0;
      z_hold       <= 4'h0;
      res          <= 4'h0;
      res_valid    <= 1'b0;
    end else begin
      state        <= next_state;
      a            <= a_n;
      b            <= b_n;
      sel          <= sel_n;
      err          <= err_n;
      key_ready    <= (next_state != S_ISSUE);
      opcode_valid <= (next_state == S_ISSUE);
      if (enter_issue) begin
        opcode <= pack_opcode(sel_n, a_n, b_n);
      end else begin
        opcode <= opcode;
      end
      pend      <= capture;
      z_hold    <= capture ? z : z_hold;
      res_valid <= pend;
      res       <= pend ? z_hold : res;
    end
  end

endmodule

// File: tb/tb_calc_opcode_builder.sv
// Self-checking bench for calc_opcode_builder with a behavioural calculator core.
// Honours CALC_RESULT_CHAIN_EN when defined for the build.
module tb_calc_opcode_builder;

  localparam int SETTLE = 3;
`ifdef CALC_RESULT_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        key_valid = 1'b0, key_is_op = 1'b0, key_clr = 1'b0;
  logic [3:0]  key_val = 4'h0;
  logic        key_ready, opcode_valid, res_valid, err;
  logic [13:0] opcode;
  logic [3:0]  z, res;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  calc_opcode_builder #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_is_op(key_is_op),
    .key_val(key_val), .key_clr(key_clr), .key_ready(key_ready), .opcode(opcode),
    .opcode_valid(opcode_valid), .z(z), .res(res), .res_valid(res_valid), .err(err)
  );

  // Calculator core driven by the opcode word.
  always_comb begin
    case (opcode[13:12])
      2'b00:   z = opcode[11:8] + opcode[7:4];
      2'b01:   z = opcode[11:8] - opcode[7:4];
      2'b10:   z = opcode[11:8] | opcode[7:4];
      default: z = 4'h0 - opcode[11:8];
    endcase
  end

  typedef struct packed {
    logic [2:0]  n;
    logic [3:0]  is_op;
    logic [15:0] vals;
    logic [13:0] exp_op;
    logic [3:0]  exp_res;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    key_clr = 1'b1;
    step();
    key_clr = 1'b0;
  endtask

  task automatic press(input bit is_op, input logic [3:0] v);
    int n = 0;
    while (!key_ready && n < 50) begin
      step();
      n++;
    end
    chk("key_ready_before_press", 32'(key_ready), 32'd1);
    key_valid = 1'b1;
    key_is_op = is_op;
    key_val   = v;
    step();
    key_valid = 1'b0;
  endtask

  // Called right after the edge that accepted the final key.
  task automatic issue_check(input string name, input logic [13:0] exp_op, input logic [3:0] exp_res);
    chk({name, "_opcode"}, 32'(opcode), 32'(exp_op));
    chk({name, "_opcode_valid"}, 32'(opcode_valid), 32'd1);
    chk({name, "_ready_low"}, 32'(key_ready), 32'd0);
    for (int k = 1; k <= SETTLE + 1; k++) begin
      step();
      chk({name, "_opvalid_window"}, 32'(opcode_valid), 32'(k < SETTLE));
      if (k <= SETTLE) begin
        chk({name, "_res_valid_early"}, 32'(res_valid), 32'd0);
      end else begin
        chk({name, "_res_valid"}, 32'(res_valid), 32'd1);
        chk({name, "_res"}, 32'(res), 32'(exp_res));
      end
    end
    step();
    chk({name, "_res_valid_pulse"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ma, mb, msel, last_res, exp_res, pre;
    bit  have_a, have_op, in_res, is_op, fire, exp_err;
    logic [3:0] v;

    vecs[0] = '{3'd3, 4'b0010, 16'h0503, 14'h0350, 4'h8};
    vecs[1] = '{3'd3, 4'b0010, 16'h0712, 14'h1270, 4'hB};
    vecs[2] = '{3'd2, 4'b0010, 16'h0035, 14'h3500, 4'hB};
    vecs[3] = '{3'd4, 4'b0100, 16'h6294, 14'h2960, 4'hF};
    vecs[4] = '{3'd4, 4'b0110, 16'h3101, 14'h1130, 4'hE};
    vecs[5] = '{3'd3, 4'b0110, 16'h0307, 14'h3700, 4'h9};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_key_ready", 32'(key_ready), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_outputs", 32'({opcode_valid, res_valid, err, res}), 32'd0);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(key_ready), 32'd1);

    // Operator in IDLE.
    press(1'b1, 4'h2);
    chk("idle_op_err", 32'(err), 32'd1);
    step();
    chk("err_pulse_end", 32'(err), 32'd0);

    // Table of complete operations.
    for (int i = 0; i < 6; i++) begin
      clr_pulse();
      for (int j = 0; j < int'(vecs[i].n); j++) begin
        press(vecs[i].is_op[j], vecs[i].vals[j*4 +: 4]);
        if (j < int'(vecs[i].n) - 1) chk("vec_no_err", 32'(err), 32'd0);
      end
      issue_check("vec", vecs[i].exp_op, vecs[i].exp_res);
    end

    // Clear during ISSUE aborts.
    clr_pulse();
    press(1'b0, 4'h3); press(1'b1, 4'h0); press(1'b0, 4'h5);
    pre = (SETTLE >= 2) ? 1 : 0;
    for (int k = 0; k < pre; k++) step();
    key_clr = 1'b1;
    step();
    key_clr = 1'b0;
    chk("clr_issue_ready", 32'(key_ready), 32'd1);
    chk("clr_opcode_kept", 32'(opcode), 32'h0350);
    for (int k = 0; k < SETTLE + 2; k++) begin
      step();
      chk("clr_issue_no_res", 32'(res_valid), 32'd0);
    end

    // Reset during ISSUE aborts.
    press(1'b0, 4'h6); press(1'b1, 4'h0); press(1'b0, 4'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_issue", 32'({key_ready, opcode, opcode_valid, res, res_valid, err}), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < SETTLE + 2; k++) begin
      step();
      chk("rst_issue_no_res", 32'(res_valid), 32'd0);
    end

    // key_valid held through ISSUE is ignored.
    press(1'b0, 4'h3); press(1'b1, 4'h0);
    key_valid = 1'b1; key_is_op = 1'b0; key_val = 4'h5;
    step();
    key_val = 4'h7;
    chk("held_first_err", 32'(err), 32'd0);
    for (int k = 1; k <= SETTLE + 1; k++) begin
      step();
      if (k == SETTLE) key_valid = 1'b0;
      chk("held_no_err", 32'(err), 32'd0);
    end
    chk("held_res_valid", 32'(res_valid), 32'd1);
    chk("held_res", 32'(res), 32'h8);
    chk("held_opcode", 32'(opcode), 32'h0350);

    // Clear beats a simultaneous digit.
    clr_pulse();
    press(1'b0, 4'h6);
    key_valid = 1'b1; key_is_op = 1'b0; key_val = 4'h9; key_clr = 1'b1;
    step();
    key_valid = 1'b0; key_clr = 1'b0;
    chk("clr_digit_no_err", 32'(err), 32'd0);
    press(1'b1, 4'h0);
    chk("clr_digit_idle", 32'(err), 32'd1);
    press(1'b0, 4'h2); press(1'b1, 4'h3);
    issue_check("neg2", 14'h3200, 4'hE);

    // Operator straight after a result.
    clr_pulse();
    press(1'b0, 4'h3); press(1'b1, 4'h0); press(1'b0, 4'h5);
    issue_check("chain_base", 14'h0350, 4'h8);
    press(1'b1, 4'h0);
`ifdef CALC_RESULT_CHAIN_EN
    chk("chain_op_no_err", 32'(err), 32'd0);
    press(1'b0, 4'h1);
    issue_check("chain", 14'h0810, 4'h9);
`else
    chk("after_res_op_err", 32'(err), 32'd1);
`endif

    // Random key streams against an abstract model.
    clr_pulse();
    have_a = 1'b0; have_op = 1'b0; in_res = 1'b0; last_res = 0; ma = 0; mb = 0; msel = 0;
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(19) == 0) begin
        clr_pulse();
        have_a = 1'b0; have_op = 1'b0; in_res = 1'b0;
      end
      is_op   = ($urandom_range(2) == 0);
      v       = 4'($urandom_range(15));
      fire    = 1'b0;
      exp_err = 1'b0;
      if (is_op && !have_a && !(CHAIN && in_res)) begin
        exp_err = 1'b1;
      end else if (!is_op && !have_op) begin
        ma = int'(v); have_a = 1'b1;
      end else if (!is_op) begin
        mb = int'(v); fire = 1'b1;
      end else begin
        if (!have_a) begin
          ma = last_res; have_a = 1'b1;
        end
        msel = int'(v) % 4; have_op = 1'b1;
        if (msel == 3) begin
          mb = 0; fire = 1'b1;
        end
      end
      in_res = 1'b0;
      press(is_op, v);
      chk("rand_err", 32'(err), 32'(exp_err));
      if (fire) begin
        case (msel)
          0:       exp_res = (ma + mb) % 16;
          1:       exp_res = (ma - mb + 16) % 16;
          2:       exp_res = ma | mb;
          default: exp_res = (16 - ma) % 16;
        endcase
        issue_check("rand", 14'(msel * 4096 + ma * 256 + mb * 16), 4'(exp_res));
        last_res = exp_res;
        have_a = 1'b0; have_op = 1'b0; in_res = CHAIN;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
